// File: rtl/perip_bridge.sv
// perip_bridge: data-side bridge from the CPU perip_* bus to a byte-lane
// masked DRAM and a 4 KiB MMIO page (LED, switches, cycle counter,
// compare timer with interrupt, misalignment status).
module perip_bridge #(
  parameter int unsigned DRAM_AW   = 14,
  parameter int unsigned LED_W     = 16,
  parameter int unsigned SW_W      = 16,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_F000
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst_n,
  input  logic [31:0]       perip_addr,
  input  logic              perip_wen,
  input  logic [1:0]        perip_mask,
  input  logic [31:0]       perip_wdata,
  output logic [31:0]       perip_rdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw,
  output logic              timer_irq
);

  localparam int unsigned DRAM_DEPTH = 1 << DRAM_AW;

  // MMIO register word offsets (addr[11:2])
  localparam logic [9:0] OFF_LED    = 10'h000;
  localparam logic [9:0] OFF_SW     = 10'h001;
  localparam logic [9:0] OFF_CYCLE  = 10'h002;
  localparam logic [9:0] OFF_TCMP   = 10'h003;
  localparam logic [9:0] OFF_TCTRL  = 10'h004;
  localparam logic [9:0] OFF_TCNT   = 10'h005;
  localparam logic [9:0] OFF_STATUS = 10'h006;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;

  // Decode / access qualification
  logic               is_mmio;
  logic [DRAM_AW-1:0] dram_idx;
  logic [9:0]         mmio_off;
  logic               misalign;
  logic               wr_ok;
  logic               dram_we;
  logic               mmio_we;

  // Lane steering
  logic [3:0]         lane_be;
  logic [31:0]        lane_data;

  // MMIO register write strobes
  logic               wr_led;
  logic               wr_tcmp;
  logic               wr_tctrl;
  logic               wr_tcnt;
  logic               wr_status;

  // Storage
  logic [31:0]        dram [DRAM_DEPTH];

  logic [LED_W-1:0]   led_q,      led_d;
  logic [SW_W-1:0]    sw_meta_q,  sw_meta_d;
  logic [SW_W-1:0]    sw_sync_q,  sw_sync_d;
  logic [31:0]        cycle_q,    cycle_d;
  logic [31:0]        tcmp_q,     tcmp_d;
  logic [31:0]        tcnt_q,     tcnt_d;
  logic               ten_q,      ten_d;
  logic               tauto_q,    tauto_d;
  logic               tpend_q,    tpend_d;
  logic               misalign_q, misalign_d;

  logic               tmatch;
  logic [31:0]        mmio_rdata;

  // Address decode, misalignment detection and write qualification
  always_comb begin
    is_mmio  = (perip_addr[31:12] == MMIO_BASE[31:12]);
    dram_idx = perip_addr[DRAM_AW+1:2];
    mmio_off = perip_addr[11:2];
    case (perip_mask)
      MASK_BYTE: misalign = 1'b0;
      MASK_HALF: misalign = perip_addr[0];
      default:   misalign = |perip_addr[1:0];
    endcase
    wr_ok   = perip_wen & ~misalign;
    dram_we = wr_ok & ~is_mmio;
    mmio_we = wr_ok & is_mmio;
  end

  // Byte-enable and replicated store data for the addressed lanes
  always_comb begin
    lane_be   = 4'b1111;
    lane_data = perip_wdata;
    case (perip_mask)
      MASK_BYTE: begin
        lane_be   = 4'b0001 << perip_addr[1:0];
        lane_data = {4{perip_wdata[7:0]}};
      end
      MASK_HALF: begin
        lane_be   = perip_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{perip_wdata[15:0]}};
      end
      default: begin
        lane_be   = 4'b1111;
        lane_data = perip_wdata;
      end
    endcase
  end

  // DRAM lane write; contents intentionally survive reset
  always_ff @(posedge cpu_clk) begin
    if (dram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) begin
          dram[dram_idx][8*i +: 8] <= lane_data[8*i +: 8];
        end
      end
    end
  end

  // MMIO register write strobes (mask ignored; always full word)
  always_comb begin
    wr_led    = mmio_we && (mmio_off == OFF_LED);
    wr_tcmp   = mmio_we && (mmio_off == OFF_TCMP);
    wr_tctrl  = mmio_we && (mmio_off == OFF_TCTRL);
    wr_tcnt   = mmio_we && (mmio_off == OFF_TCNT);
    wr_status = mmio_we && (mmio_off == OFF_STATUS);
  end

  // Simple registers: LED, switch synchroniser, cycle counter, compare, status
  always_comb begin
    led_d      = led_q;
    sw_meta_d  = sw;
    sw_sync_d  = sw_meta_q;
    cycle_d    = cycle_q + 32'd1;
    tcmp_d     = tcmp_q;
    misalign_d = misalign_q;
    if (wr_led) begin
      led_d = LED_W'(perip_wdata);
    end
    if (wr_tcmp) begin
      tcmp_d = perip_wdata;
    end
    if (wr_status && perip_wdata[0]) begin
      misalign_d = 1'b0;
    end
    // a new misaligned store outranks a simultaneous clear
    if (perip_wen && misalign) begin
      misalign_d = 1'b1;
    end
  end

  // Timer: load beats match, match beats increment; set beats W1C
  always_comb begin
    tcnt_d  = tcnt_q;
    ten_d   = ten_q;
    tauto_d = tauto_q;
    tpend_d = tpend_q;
    tmatch  = ten_q && (tcnt_q == tcmp_q) && !wr_tcnt;
    if (wr_tcnt) begin
      tcnt_d = perip_wdata;
    end else if (tmatch) begin
      if (tauto_q) begin
        tcnt_d = '0;
      end else begin
        ten_d = 1'b0;
      end
    end else if (ten_q) begin
      tcnt_d = tcnt_q + 32'd1;
    end
    // software-written enable overrides a one-shot auto-clear
    if (wr_tctrl) begin
      ten_d   = perip_wdata[0];
      tauto_d = perip_wdata[2];
      if (perip_wdata[1]) begin
        tpend_d = 1'b0;
      end
    end
    if (tmatch) begin
      tpend_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      cycle_q    <= '0;
      tcmp_q     <= '0;
      tcnt_q     <= '0;
      ten_q      <= 1'b0;
      tauto_q    <= 1'b0;
      tpend_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      cycle_q    <= cycle_d;
      tcmp_q     <= tcmp_d;
      tcnt_q     <= tcnt_d;
      ten_q      <= ten_d;
      tauto_q    <= tauto_d;
      tpend_q    <= tpend_d;
      misalign_q <= misalign_d;
    end
  end

  // Combinational read mux: MMIO page or full aligned DRAM word
  always_comb begin
    case (mmio_off)
      OFF_LED:    mmio_rdata = 32'(led_q);
      OFF_SW:     mmio_rdata = 32'(sw_sync_q);
      OFF_CYCLE:  mmio_rdata = cycle_q;
      OFF_TCMP:   mmio_rdata = tcmp_q;
      OFF_TCTRL:  mmio_rdata = {29'd0, tauto_q, tpend_q, ten_q};
      OFF_TCNT:   mmio_rdata = tcnt_q;
      OFF_STATUS: mmio_rdata = {31'd0, misalign_q};
      default:    mmio_rdata = '0;
    endcase
    perip_rdata = is_mmio ? mmio_rdata : dram[dram_idx];
  end

  assign led       = led_q;
  assign timer_irq = tpend_q;

endmodule

// File: tb/tb_perip_bridge.sv
// Directed self-checking bench for perip_bridge.
module tb_perip_bridge;

  localparam logic [31:0] A_LED    = 32'hFFFF_F000;
  localparam logic [31:0] A_SW     = 32'hFFFF_F004;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_F008;
  localparam logic [31:0] A_TCMP   = 32'hFFFF_F00C;
  localparam logic [31:0] A_TCTRL  = 32'hFFFF_F010;
  localparam logic [31:0] A_TCNT   = 32'hFFFF_F014;
  localparam logic [31:0] A_STATUS = 32'hFFFF_F018;
  localparam logic [31:0] A_HOLE   = 32'hFFFF_F020;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic [31:0] perip_addr;
  logic        perip_wen;
  logic [1:0]  perip_mask;
  logic [31:0] perip_wdata;
  logic [31:0] perip_rdata;
  logic [15:0] led;
  logic [15:0] sw;
  logic        timer_irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  perip_bridge dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst_n   (cpu_rst_n),
    .perip_addr  (perip_addr),
    .perip_wen   (perip_wen),
    .perip_mask  (perip_mask),
    .perip_wdata (perip_wdata),
    .perip_rdata (perip_rdata),
    .led         (led),
    .sw          (sw),
    .timer_irq   (timer_irq)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  // Called just after a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    perip_addr  = a;
    perip_wdata = d;
    perip_mask  = m;
    perip_wen   = 1'b1;
    @(negedge cpu_clk);
    perip_wen   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    perip_addr = a;
    perip_wen  = 1'b0;
    #1;
    d = perip_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    total_cnt++;
    if (led !== 16'h0) $display("FAIL reset_led got=%h exp=0000", led); else pass_cnt++;
    total_cnt++;
    if (timer_irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", timer_irq); else pass_cnt++;
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL reset_tcnt got=%h exp=0", d); else pass_cnt++;
    rd(A_TCTRL, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL reset_tctrl got=%h exp=0", d); else pass_cnt++;
    rd(A_STATUS, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL reset_status got=%h exp=0", d); else pass_cnt++;
  endtask

  task automatic test_lanes;
    logic [31:0] d;
    wr(32'h100, 32'h1122_3344, 2'b10);
    rd(32'h100, d);
    total_cnt++;
    if (d !== 32'h1122_3344) $display("FAIL lane_word got=%h exp=11223344", d); else pass_cnt++;
    wr(32'h101, 32'hFFFF_FFAA, 2'b00);
    rd(32'h100, d);
    total_cnt++;
    if (d !== 32'h1122_AA44) $display("FAIL lane_byte got=%h exp=1122aa44", d); else pass_cnt++;
    wr(32'h102, 32'h1234_BEEF, 2'b01);
    rd(32'h100, d);
    total_cnt++;
    if (d !== 32'hBEEF_AA44) $display("FAIL lane_half got=%h exp=beefaa44", d); else pass_cnt++;
    wr(32'h104, 32'h0000_0000, 2'b10);
    wr(32'h107, 32'h0000_0077, 2'b00);
    wr(32'h104, 32'h0000_5566, 2'b01);
    rd(32'h104, d);
    total_cnt++;
    if (d !== 32'h7700_5566) $display("FAIL lane_mix got=%h exp=77005566", d); else pass_cnt++;
    wr(32'h108, 32'hCAFE_F00D, 2'b11);
    rd(32'h108, d);
    total_cnt++;
    if (d !== 32'hCAFE_F00D) $display("FAIL lane_mask11 got=%h exp=cafef00d", d); else pass_cnt++;
  endtask

  task automatic test_misalign_wrap;
    logic [31:0] d;
    wr(32'h200, 32'h0102_0304, 2'b10);
    wr(32'h202, 32'hDEAD_BEEF, 2'b10);
    rd(32'h200, d);
    total_cnt++;
    if (d !== 32'h0102_0304) $display("FAIL misalign_word_dram got=%h exp=01020304", d); else pass_cnt++;
    rd(A_STATUS, d);
    total_cnt++;
    if (d !== 32'h1) $display("FAIL misalign_status_set got=%h exp=1", d); else pass_cnt++;
    wr(A_STATUS, 32'h1, 2'b10);
    rd(A_STATUS, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL misalign_status_clr got=%h exp=0", d); else pass_cnt++;
    wr(32'h201, 32'h0000_9999, 2'b01);
    rd(32'h200, d);
    total_cnt++;
    if (d !== 32'h0102_0304) $display("FAIL misalign_half_dram got=%h exp=01020304", d); else pass_cnt++;
    wr(A_LED + 32'h2, 32'h0000_1234, 2'b10);
    total_cnt++;
    if (led !== 16'h0) $display("FAIL misalign_mmio_led got=%h exp=0000", led); else pass_cnt++;
    wr(A_STATUS, 32'h1, 2'b10);
    wr(32'h0000_0000, 32'h1111_1111, 2'b10);
    wr(32'h0001_0000, 32'h5A5A_5A5A, 2'b10);
    rd(32'h0000_0000, d);
    total_cnt++;
    if (d !== 32'h5A5A_5A5A) $display("FAIL wrap_alias got=%h exp=5a5a5a5a", d); else pass_cnt++;
  endtask

  task automatic test_timer_autoreload;
    logic [31:0] d;
    logic [31:0] exp_cnt [4];
    logic        exp_irq [4];
    exp_cnt = '{32'd1, 32'd2, 32'd3, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1};
    wr(A_TCMP, 32'd3, 2'b10);
    wr(A_TCNT, 32'd0, 2'b10);
    wr(A_TCTRL, 32'h5, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge cpu_clk);
      rd(A_TCNT, d);
      total_cnt++;
      if (d !== exp_cnt[i] || timer_irq !== exp_irq[i])
        $display("FAIL auto_seq%0d got cnt=%0d irq=%b exp cnt=%0d irq=%b", i, d, timer_irq, exp_cnt[i], exp_irq[i]);
      else pass_cnt++;
    end
    @(negedge cpu_clk);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'd1 || timer_irq !== 1'b1) $display("FAIL auto_hold got cnt=%0d irq=%b exp cnt=1 irq=1", d, timer_irq); else pass_cnt++;
    wr(A_TCTRL, 32'h7, 2'b10);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'd2 || timer_irq !== 1'b0) $display("FAIL auto_w1c got cnt=%0d irq=%b exp cnt=2 irq=0", d, timer_irq); else pass_cnt++;
    @(negedge cpu_clk);
    wr(A_TCTRL, 32'h7, 2'b10);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'd0 || timer_irq !== 1'b1) $display("FAIL auto_w1c_vs_set got cnt=%0d irq=%b exp cnt=0 irq=1", d, timer_irq); else pass_cnt++;
    wr(A_TCTRL, 32'h2, 2'b10);
    total_cnt++;
    if (timer_irq !== 1'b0) $display("FAIL auto_stop_irq got=%b exp=0", timer_irq); else pass_cnt++;
  endtask

  task automatic test_timer_oneshot;
    logic [31:0] d;
    wr(A_TCMP, 32'd2, 2'b10);
    wr(A_TCNT, 32'd0, 2'b10);
    wr(A_TCTRL, 32'h1, 2'b10);
    repeat (3) @(negedge cpu_clk);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'd2) $display("FAIL oneshot_cnt got=%0d exp=2", d); else pass_cnt++;
    rd(A_TCTRL, d);
    total_cnt++;
    if (d !== 32'h2 || timer_irq !== 1'b1) $display("FAIL oneshot_ctrl got ctrl=%h irq=%b exp ctrl=2 irq=1", d, timer_irq); else pass_cnt++;
    repeat (2) @(negedge cpu_clk);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'd2) $display("FAIL oneshot_stopped got=%0d exp=2", d); else pass_cnt++;
    wr(A_TCTRL, 32'h2, 2'b10);
    wr(A_TCNT, 32'd0, 2'b10);
    wr(A_TCTRL, 32'h1, 2'b10);
    repeat (2) @(negedge cpu_clk);
    wr(A_TCNT, 32'h100, 2'b10);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'h100 || timer_irq !== 1'b0) $display("FAIL load_vs_match got cnt=%h irq=%b exp cnt=100 irq=0", d, timer_irq); else pass_cnt++;
    @(negedge cpu_clk);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'h101) $display("FAIL load_then_count got=%h exp=101", d); else pass_cnt++;
    wr(A_TCTRL, 32'h0, 2'b10);
  endtask

  task automatic test_mmio_io;
    logic [31:0] d;
    logic [31:0] c1;
    logic [31:0] c2;
    wr(A_LED, 32'hFFFF_A5A5, 2'b10);
    total_cnt++;
    if (led !== 16'hA5A5) $display("FAIL led_out got=%h exp=a5a5", led); else pass_cnt++;
    rd(A_LED, d);
    total_cnt++;
    if (d !== 32'h0000_A5A5) $display("FAIL led_read got=%h exp=0000a5a5", d); else pass_cnt++;
    sw = 16'h0F0F;
    @(negedge cpu_clk);
    rd(A_SW, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL sw_sync1 got=%h exp=0", d); else pass_cnt++;
    @(negedge cpu_clk);
    rd(A_SW, d);
    total_cnt++;
    if (d !== 32'h0000_0F0F) $display("FAIL sw_sync2 got=%h exp=00000f0f", d); else pass_cnt++;
    wr(A_HOLE, 32'hFFFF_FFFF, 2'b10);
    rd(A_HOLE, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL hole_read got=%h exp=0", d); else pass_cnt++;
    rd(A_CYCLE, c1);
    repeat (5) @(negedge cpu_clk);
    rd(A_CYCLE, c2);
    total_cnt++;
    if (c2 - c1 !== 32'd5) $display("FAIL cycle_delta got=%0d exp=5", c2 - c1); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] d;
    wr(32'h300, 32'h600D_F00D, 2'b10);
    wr(A_LED, 32'h0000_00FF, 2'b10);
    wr(A_TCMP, 32'd1, 2'b10);
    wr(A_TCNT, 32'd0, 2'b10);
    wr(A_TCTRL, 32'h5, 2'b10);
    repeat (3) @(negedge cpu_clk);
    wr(A_TCMP, 32'h1000, 2'b10);
    repeat (4) @(negedge cpu_clk);
    total_cnt++;
    if (timer_irq !== 1'b1 || led !== 16'h00FF) $display("FAIL pre_reset got irq=%b led=%h exp irq=1 led=00ff", timer_irq, led); else pass_cnt++;
    #2;
    cpu_rst_n = 1'b0;
    #1;
    total_cnt++;
    if (led !== 16'h0 || timer_irq !== 1'b0) $display("FAIL async_reset_out got led=%h irq=%b exp led=0000 irq=0", led, timer_irq); else pass_cnt++;
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL async_reset_tcnt got=%h exp=0", d); else pass_cnt++;
    rd(A_CYCLE, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL async_reset_cycle got=%h exp=0", d); else pass_cnt++;
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    repeat (3) @(negedge cpu_clk);
    rd(A_TCNT, d);
    total_cnt++;
    if (d !== 32'h0) $display("FAIL post_reset_tcnt got=%h exp=0", d); else pass_cnt++;
    rd(32'h300, d);
    total_cnt++;
    if (d !== 32'h600D_F00D) $display("FAIL dram_retained got=%h exp=600df00d", d); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_rst_n   = 1'b0;
    perip_addr  = 32'h0;
    perip_wen   = 1'b0;
    perip_mask  = 2'b10;
    perip_wdata = 32'h0;
    sw          = 16'h0;
    repeat (3) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
    test_reset();
    test_lanes();
    test_misalign_wrap();
    test_timer_autoreload();
    test_timer_oneshot();
    test_mmio_io();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
